multicycle_sequencer: RTL

//  Main FSM for the multicycle RV32I datapath. Steps each instruction through

---
 rtl/multicycle_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Main control FSM for a multicycle RV32I datapath.
// Each instruction steps through FETCH, DECODE, EXECUTE, (MEM), WRITEBACK. The FSM drives
// the IR, PC, register-file and memory enables. Instruction fetch and load data share
// the single memory read port, selected by mem_addr_sel.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   opcode        instruction[6:0], classified in DECODE
//   branch_taken  branch compare result, used only in WRITEBACK
//   halt_req      level request to stop after the current instruction
//   ir_load       load instruction register from memory read data
//   mem_rd_en     memory read active
//   mem_addr_sel  0 = PC, 1 = ALU result
//   mem_write_en  store strobe
//   reg_write_en  register-file write strobe
//   pc_we/pc_sel  PC update strobe / source (00 hold, 01 +4, 10 +imm, 11 (rs1+imm)&~1)
//   halted, trap  FSM in HALT / sticky illegal-opcode trap
//   state_dbg     encoded current state
//   retired       count of completed instructions (wraps)
module multicycle_sequencer #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  input  logic                halt_req,
  output logic                ir_load,
  output logic                mem_rd_en,
  output logic                mem_addr_sel,
  output logic                mem_write_en,
  output logic                reg_write_en,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                halted,
  output logic                trap,
  output logic [3:0]          state_dbg,
  output logic [RETIRE_W-1:0] retired
);

  // A latency of 0 is meaningless for a registered memory; run it as 1. Clamp to 4-bit counter.
  localparam int unsigned Lat = (MEM_LATENCY == 0) ? 1 : ((MEM_LATENCY > 15) ? 15 : MEM_LATENCY);
  localparam logic [3:0] WaitInit = 4'(Lat - 1);

  typedef enum logic [3:0] {
    StBoot      = 4'd0,
    StFetch     = 4'd1,
    StDecode    = 4'd2,
    StExecute   = 4'd3,
    StMem       = 4'd4,
    StWriteback = 4'd5,
    StHalt      = 4'd6,
    StTrap      = 4'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore, ClsOpImm, ClsOp
  } cls_e;

  state_e                state_q;
  cls_e                  cls_q;
  logic [3:0]            wait_q;
  logic [RETIRE_W-1:0]   retired_q;

  cls_e                  dec_cls;
  logic                  dec_legal;

  always_comb begin
    dec_cls   = ClsOp;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110111: dec_cls = ClsLui;
      7'b0010111: dec_cls = ClsAuipc;
      7'b1101111: dec_cls = ClsJal;
      7'b1100111: dec_cls = ClsJalr;
      7'b1100011: dec_cls = ClsBranch;
      7'b0000011: dec_cls = ClsLoad;
      7'b0100011: dec_cls = ClsStore;
      7'b0010011: dec_cls = ClsOpImm;
      7'b0110011: dec_cls = ClsOp;
      default:    dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      cls_q     <= ClsOp;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q <= StFetch;
          wait_q  <= WaitInit;
        end
        StFetch: begin
          if (wait_q == 4'd0) state_q <= StDecode;
          else                wait_q  <= wait_q - 4'd1;
        end
        StDecode: begin
          if (dec_legal) begin
            cls_q   <= dec_cls;
            state_q <= StExecute;
          end else begin
            state_q <= StTrap;
          end
        end
        StExecute: begin
          if (cls_q == ClsLoad || cls_q == ClsStore) begin
            state_q <= StMem;
            wait_q  <= WaitInit;
          end else begin
            state_q <= StWriteback;
          end
        end
        StMem: begin
          // Stores complete in one cycle; loads wait out the read latency.
          if (cls_q == ClsStore || wait_q == 4'd0) state_q <= StWriteback;
          else                                     wait_q  <= wait_q - 4'd1;
        end
        StWriteback: begin
          retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
          if (halt_req) begin
            state_q <= StHalt;
          end else begin
            state_q <= StFetch;
            wait_q  <= WaitInit;
          end
        end
        StHalt: begin
          if (!halt_req) begin
            state_q <= StFetch;
            wait_q  <= WaitInit;
          end
        end
        StTrap: state_q <= StTrap;
        default: state_q <= StBoot;
      endcase
    end
  end

  // Moore decode from the state register and latched class; branch_taken only matters
  // for the PC source while in WRITEBACK.
  always_comb begin
    ir_load      = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr_sel = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_rd_en = 1'b1;
        ir_load   = (wait_q == 4'd0);
      end
      StMem: begin
        mem_addr_sel = 1'b1;
        if (cls_q == ClsStore) mem_write_en = 1'b1;
        else                   mem_rd_en    = 1'b1;
      end
      StWriteback: begin
        pc_we        = 1'b1;
        reg_write_en = !(cls_q == ClsBranch || cls_q == ClsStore);
        if (cls_q == ClsJal || (cls_q == ClsBranch && branch_taken)) pc_sel = 2'b10;
        else if (cls_q == ClsJalr)                                    pc_sel = 2'b11;
        else                                                          pc_sel = 2'b01;
      end
      default: ;
    endcase
  end

  assign halted    = (state_q == StHalt);
  assign trap      = (state_q == StTrap);
  assign state_dbg = state_q;
  assign retired   = retired_q;

endmodule
